// File: rtl/prog_loader.sv
// Framed serial program loader: parses HEADER/LEN/opcodes/CSUM bytes, writes the
// opcodes into the CPU instruction RAM and holds the CPU in reset until a frame checks out.
module prog_loader #(
    parameter logic [7:0] HEADER = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       write,
    output logic [7:0] writeop,
    output logic [7:0] writeaddr,
    output logic       cpu_rst,
    output logic       done,
    output logic       error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_RUN,
        S_ERR
    } state_t;

    state_t     state_q;
    logic [8:0] cnt_q;
    logic [7:0] addr_q;
    logic [7:0] sum_q;
    logic       write_q;
    logic [7:0] writeop_q;
    logic [7:0] writeaddr_q;
    logic       cpu_rst_q;
    logic       done_q;
    logic       error_q;

    // NOTE: every register here is assigned with <= so all reads in this block see
    // the pre-edge values; a blocking '=' would let later statements see updated state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            sum_q       <= '0;
            write_q     <= 1'b0;
            writeop_q   <= '0;
            writeaddr_q <= '0;
            cpu_rst_q   <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            // The write strobe is a single-cycle pulse; writeop/writeaddr hold otherwise.
            write_q <= 1'b0;
            if (rx_valid) begin
                unique case (state_q)
                    S_IDLE, S_ERR: begin
                        if (rx_data == HEADER) begin
                            done_q    <= 1'b0;
                            error_q   <= 1'b0;
                            cpu_rst_q <= 1'b1;
                            state_q   <= S_LEN;
                        end
                    end
                    S_LEN: begin
                        // A length byte of zero encodes a full 256-opcode frame.
                        cnt_q   <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                        sum_q   <= '0;
                        addr_q  <= '0;
                        state_q <= S_DATA;
                    end
                    S_DATA: begin
                        write_q     <= 1'b1;
                        writeop_q   <= rx_data;
                        writeaddr_q <= addr_q;
                        sum_q       <= sum_q + rx_data;
                        addr_q      <= addr_q + 8'd1;
                        cnt_q       <= cnt_q - 9'd1;
                        if (cnt_q == 9'd1) begin
                            state_q <= S_CSUM;
                        end
                    end
                    S_CSUM: begin
                        if (rx_data == sum_q) begin
                            done_q    <= 1'b1;
                            cpu_rst_q <= 1'b0;
                            state_q   <= S_RUN;
                        end else begin
                            error_q <= 1'b1;
                            state_q <= S_ERR;
                        end
                    end
                    S_RUN: begin
                        // A new header while running restarts the load with the CPU held.
                        if (rx_data == HEADER) begin
                            cpu_rst_q <= 1'b1;
                            done_q    <= 1'b0;
                            state_q   <= S_LEN;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign write     = write_q;
    assign writeop   = writeop_q;
    assign writeaddr = writeaddr_q;
    assign cpu_rst   = cpu_rst_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule
